audio_stream_bridge: RTL and testbench



---
 rtl/audio_pkg.sv | 22 ++
 rtl/sat_counter.sv | 19 +
 rtl/audio_stream_bridge.sv | 153 +++++++++++++++
 tb/tb_audio_stream_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio stream encodings and default frame geometry
package audio_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_CH_COUNT     = 2;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_FX     = 2'b01,
    MODE_MUTE   = 2'b10,
    MODE_SWAP   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_FX   = 3'd3,
    ST_WR   = 3'd4
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/audio_stream_bridge.sv
// rtl/audio_stream_bridge.sv - moves one frame at a time from the I2S rx FIFO to the tx FIFO
module audio_stream_bridge
  import audio_pkg::*;
#(
  parameter  int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter  int CH_COUNT     = DEF_CH_COUNT,
  parameter  int FX_TIMEOUT   = 64,
  parameter  int CNT_WIDTH    = 16,
  localparam int DATA_WIDTH   = SAMPLE_WIDTH * CH_COUNT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic                  adcfifo_empty,
  output logic                  adcfifo_read,
  input  logic [DATA_WIDTH-1:0] adcfifo_readdata,
  input  logic                  dacfifo_full,
  output logic                  dacfifo_write,
  output logic [DATA_WIDTH-1:0] dacfifo_writedata,
  output logic                  fx_start,
  output logic [DATA_WIDTH-1:0] fx_frame,
  input  logic                  fx_done,
  input  logic [DATA_WIDTH-1:0] fx_result,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  fx_timeout_count
);

  localparam int TW = (FX_TIMEOUT > 2) ? $clog2(FX_TIMEOUT) : 1;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  rd_d, wr_d, fxs_d;
  logic [DATA_WIDTH-1:0] wdata_d, fxf_d;
  logic                  frame_inc, timeout_inc;
  logic [DATA_WIDTH-1:0] swapped;

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_swap
    assign swapped[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
      frame_q[(CH_COUNT-1-i)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      mode_q            <= MODE_BYPASS;
      frame_q           <= '0;
      out_q             <= '0;
      timer_q           <= '0;
      adcfifo_read      <= 1'b0;
      dacfifo_write     <= 1'b0;
      dacfifo_writedata <= '0;
      fx_start          <= 1'b0;
      fx_frame          <= '0;
    end else begin
      state_q           <= state_d;
      mode_q            <= mode_d;
      frame_q           <= frame_d;
      out_q             <= out_d;
      timer_q           <= timer_d;
      adcfifo_read      <= rd_d;
      dacfifo_write     <= wr_d;
      dacfifo_writedata <= wdata_d;
      fx_start          <= fxs_d;
      fx_frame          <= fxf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    frame_d     = frame_q;
    out_d       = out_q;
    timer_d     = timer_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    wdata_d     = dacfifo_writedata;
    fxs_d       = 1'b0;
    fxf_d       = fx_frame;
    frame_inc   = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!adcfifo_empty) begin
          mode_d  = mode_e'(mode);
          rd_d    = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        frame_d = adcfifo_readdata;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        if (mode_q == MODE_FX) begin
          fxs_d   = 1'b1;
          fxf_d   = frame_q;
          timer_d = '0;
          state_d = ST_FX;
        end else begin
          case (mode_q)
            MODE_MUTE: out_d = '0;
            MODE_SWAP: out_d = swapped;
            default:   out_d = frame_q;
          endcase
          state_d = ST_WR;
        end
      end
      ST_FX: begin
        // Compare one below the limit so the write lands FX_TIMEOUT cycles after fx_start.
        if (fx_done) begin
          out_d   = fx_result;
          state_d = ST_WR;
        end else if (timer_q == TW'(FX_TIMEOUT - 2)) begin
          out_d       = frame_q;
          timeout_inc = 1'b1;
          state_d     = ST_WR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WR: begin
        if (!dacfifo_full) begin
          wr_d      = 1'b1;
          wdata_d   = out_q;
          frame_inc = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (frame_inc),
    .count   (frame_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (timeout_inc),
    .count   (fx_timeout_count)
  );

endmodule

// File: tb/tb_audio_stream_bridge.sv
// tb/tb_audio_stream_bridge.sv - scoreboard bench for audio_stream_bridge
module tb_audio_stream_bridge;
  import audio_pkg::*;

  localparam int DW  = 32;
  localparam int FXT = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          adcfifo_empty = 1'b1;
  logic [DW-1:0] adcfifo_readdata = '0;
  logic          dacfifo_full = 1'b0;
  logic          fx_done = 1'b0;
  logic [DW-1:0] fx_result = '0;

  logic          adcfifo_read, dacfifo_write, fx_start, busy;
  logic [DW-1:0] dacfifo_writedata, fx_frame;
  logic [15:0]   frame_count, fx_timeout_count;

  logic          d2_adcfifo_read, d2_dacfifo_write, d2_fx_start, d2_busy;
  logic [DW-1:0] d2_dacfifo_writedata, d2_fx_frame;
  logic [1:0]    d2_frame_count, d2_fx_timeout_count;

  audio_stream_bridge dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .adcfifo_empty(adcfifo_empty), .adcfifo_read(adcfifo_read), .adcfifo_readdata(adcfifo_readdata),
    .dacfifo_full(dacfifo_full), .dacfifo_write(dacfifo_write), .dacfifo_writedata(dacfifo_writedata),
    .fx_start(fx_start), .fx_frame(fx_frame), .fx_done(fx_done), .fx_result(fx_result),
    .busy(busy), .frame_count(frame_count), .fx_timeout_count(fx_timeout_count)
  );

  audio_stream_bridge #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .adcfifo_empty(adcfifo_empty), .adcfifo_read(d2_adcfifo_read), .adcfifo_readdata(adcfifo_readdata),
    .dacfifo_full(dacfifo_full), .dacfifo_write(d2_dacfifo_write), .dacfifo_writedata(d2_dacfifo_writedata),
    .fx_start(d2_fx_start), .fx_frame(d2_fx_frame), .fx_done(fx_done), .fx_result(fx_result),
    .busy(d2_busy), .frame_count(d2_frame_count), .fx_timeout_count(d2_fx_timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   since = 1000;
  int   n_reads = 0;
  int   n_writes = 0;
  logic wr_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (adcfifo_read) begin
        check("read_spacing_ok", 64'(since >= 3), 64'd1);
        since = 0;
        n_reads++;
      end else begin
        since++;
      end
      if (dacfifo_write) begin
        n_writes++;
        check("write_single_cycle", 64'(wr_prev), 64'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got 0x%0h, expected no write", dacfifo_writedata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("writedata", 64'(dacfifo_writedata), 64'(e.data));
          if (e.lat >= 0) check("read_to_write_latency", 64'(since), 64'(e.lat));
        end
      end
      wr_prev = dacfifo_write;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_read();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!adcfifo_read && t < 200);
    if (!adcfifo_read) check("read_wait_expired", 64'd1, 64'd0);
  endtask

  task automatic wait_fx_start();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!fx_start && t < 50);
    if (!fx_start) check("fx_start_wait_expired", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || sb.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy || sb.size() != 0) begin
      check("drain_expired", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic push_frame(input logic [1:0] m, input logic [DW-1:0] d,
                            input logic [DW-1:0] e, input int lat);
    sb.push_back('{e, lat});
    mode             = m;
    adcfifo_readdata = d;
    adcfifo_empty    = 1'b0;
    wait_read();
    adcfifo_empty = 1'b1;
    tick(1);
  endtask

  initial begin
    int rd_before;
    int wr_before;

    tick(2);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_read", 64'(adcfifo_read), 64'd0);
    check("reset_write", 64'(dacfifo_write), 64'd0);
    check("reset_writedata", 64'(dacfifo_writedata), 64'd0);
    check("reset_fx_start", 64'(fx_start), 64'd0);
    check("reset_frame_count", 64'(frame_count), 64'd0);
    check("reset_timeout_count", 64'(fx_timeout_count), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // bypass, back to back
    push_frame(2'b00, 32'h1234_ABCD, 32'h1234_ABCD, 3);
    push_frame(2'b00, 32'h0001_FFFF, 32'h0001_FFFF, 3);
    drain();
    check("bypass_frame_count", 64'(frame_count), 64'd2);

    // swap then mute
    push_frame(2'b11, 32'h1111_2222, 32'h2222_1111, 3);
    drain();
    check("swap_frame_count", 64'(frame_count), 64'd3);
    push_frame(2'b10, 32'h7FFF_8000, 32'h0000_0000, 3);
    drain();
    tick(3);
    check("mute_frame_count", 64'(frame_count), 64'd4);
    check("writedata_hold", 64'(dacfifo_writedata), 64'd0);

    // effect handshake, fx_done 5 cycles after fx_start
    push_frame(2'b01, 32'h0100_0200, 32'h0080_0100, 9);
    wait_fx_start();
    check("fx_frame", 64'(fx_frame), 64'h0100_0200);
    tick(5);
    fx_result = 32'h0080_0100;
    fx_done   = 1'b1;
    tick(1);
    fx_done = 1'b0;
    drain();
    check("fx_timeout_count_zero", 64'(fx_timeout_count), 64'd0);
    check("fx_frame_count", 64'(frame_count), 64'd5);

    // timeout falls back to the dry frame
    push_frame(2'b01, 32'h0A0B_0C0D, 32'h0A0B_0C0D, 2 + FXT);
    drain();
    check("timeout_count_one", 64'(fx_timeout_count), 64'd1);
    wr_before = n_writes;
    fx_result = 32'hDEAD_BEEF;
    fx_done   = 1'b1;
    tick(4);
    fx_done = 1'b0;
    tick(2);
    check("late_fx_done_no_write", 64'(n_writes), 64'(wr_before));
    check("late_fx_done_idle", 64'(busy), 64'd0);
    check("timeout_frame_count", 64'(frame_count), 64'd6);
    check("timeout_count_after_late", 64'(fx_timeout_count), 64'd1);

    // backpressure with mode toggling and a second frame pending
    dacfifo_full = 1'b1;
    sb.push_back('{32'h5678_1234, 21});
    mode             = 2'b11;
    adcfifo_readdata = 32'h1234_5678;
    adcfifo_empty    = 1'b0;
    wait_read();
    mode = 2'b10;
    tick(1);
    adcfifo_readdata = 32'hCAFE_0001;
    mode             = 2'b00;
    rd_before        = n_reads;
    wr_before        = n_writes;
    tick(19);
    check("bp_no_write_while_full", 64'(n_writes), 64'(wr_before));
    check("bp_no_extra_read", 64'(n_reads), 64'(rd_before));
    check("bp_busy", 64'(busy), 64'd1);
    sb.push_back('{32'hCAFE_0001, 3});
    dacfifo_full = 1'b0;
    wait_read();
    adcfifo_empty = 1'b1;
    check("bp_one_write_on_release", 64'(n_writes), 64'(wr_before + 1));
    tick(1);
    drain();
    check("bp_frame_count", 64'(frame_count), 64'd8);
    check("sat_frame_count_pre", 64'(d2_frame_count), 64'd3);

    // reset while in FX
    mode             = 2'b01;
    adcfifo_readdata = 32'h5555_6666;
    adcfifo_empty    = 1'b0;
    wait_read();
    adcfifo_empty = 1'b1;
    wait_fx_start();
    tick(3);
    wr_before = n_writes;
    reset_n   = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fx_frame", 64'(fx_frame), 64'd0);
    check("rst_writedata", 64'(dacfifo_writedata), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_timeout_count", 64'(fx_timeout_count), 64'd0);
    check("rst_strobes", 64'({adcfifo_read, dacfifo_write, fx_start}), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check("rst_no_write", 64'(n_writes), 64'(wr_before));

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      push_frame(2'b00, 32'h0000_0010 + 32'h0101_0101 * i, 32'h0000_0010 + 32'h0101_0101 * i, 3);
    end
    drain();
    check("sat_wide_count", 64'(frame_count), 64'd5);
    check("sat_narrow_count", 64'(d2_frame_count), 64'd3);
    check("sat_timeout_count", 64'(fx_timeout_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
